// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-cycle dual-port RAM (ram_mc).
package ram_pkg;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_BUSY = 2'd1,
        PS_ERR  = 2'd2,
        PS_DONE = 2'd3
    } port_state_t;

    localparam int unsigned BYTE_W = 8;

    // The counter holds LAT-1 at most; keep at least one bit for LAT=1.
    function automatic int unsigned cnt_w(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    function automatic int unsigned byte_off_w(input int unsigned data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

endpackage

// File: rtl/ram_port_ctl.sv
// Per-port handshake FSM: address latch, range/alignment check, latency counter.
module ram_port_ctl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10,
    parameter int unsigned LAT    = 2,
    parameter int unsigned OFF_W  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_rdy,
    output logic              o_exc,
    output logic              o_fire,
    output logic [IDX_W-1:0]  o_idx
);

    localparam int unsigned        CW       = cnt_w(LAT);
    localparam logic [CW-1:0]      CNT_INIT = CW'(LAT - 1);
    localparam logic [ADDR_W:0]    DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    port_state_t       r_state;
    logic [CW-1:0]     r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] w_word;
    logic              w_bad;

    // Range check on the full-width word index; truncation happens only when latching.
    always_comb begin
        w_word = i_addr >> OFF_W;
        w_bad  = ({1'b0, w_word} >= DEPTH_X) || ((i_addr & OFF_MASK) != '0);
    end

    assign o_fire = (r_state == PS_BUSY) && (r_cnt == '0);
    assign o_idx  = r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PS_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            o_rdy   <= 1'b1;
            o_exc   <= 1'b0;
        end else begin
            case (r_state)
                PS_IDLE: begin
                    if (i_req) begin
                        r_idx <= w_word[IDX_W-1:0];
                        o_rdy <= 1'b0;
                        if (w_bad) begin
                            o_exc   <= 1'b1;
                            r_state <= PS_ERR;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= PS_BUSY;
                        end
                    end
                end
                PS_BUSY: begin
                    if (r_cnt == '0) begin
                        o_rdy   <= 1'b1;
                        r_state <= PS_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PS_ERR: begin
                    o_rdy   <= 1'b1;
                    r_state <= PS_DONE;
                end
                PS_DONE: begin
                    if (!i_req) begin
                        o_exc   <= 1'b0;
                        r_state <= PS_IDLE;
                    end
                end
                default: r_state <= PS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ram_mc.sv
// Multi-cycle dual-port data RAM with independent read/write handshakes.
// Define RAM_ALIGN_CHECK_EN for byte addressing with a misalignment exception.
module ram_mc
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_line,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] r_line,
    output logic              rrdy,
    output logic              wrdy,
    output logic              r_exc,
    output logic              w_exc
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef RAM_ALIGN_CHECK_EN
    localparam int unsigned OFF_W = byte_off_w(DATA_W);
`else
    localparam int unsigned OFF_W = 0;
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_wdata;
    logic              w_r_fire;
    logic              w_w_fire;
    logic [IDX_W-1:0]  w_r_idx;
    logic [IDX_W-1:0]  w_w_idx;

    ram_port_ctl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .LAT(RD_LAT), .OFF_W(OFF_W)
    ) u_rd (
        .clk(clk), .rst(rst), .i_req(read), .i_addr(r_addr),
        .o_rdy(rrdy), .o_exc(r_exc), .o_fire(w_r_fire), .o_idx(w_r_idx)
    );

    ram_port_ctl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .LAT(WR_LAT), .OFF_W(OFF_W)
    ) u_wr (
        .clk(clk), .rst(rst), .i_req(write), .i_addr(w_addr),
        .o_rdy(wrdy), .o_exc(w_exc), .o_fire(w_w_fire), .o_idx(w_w_idx)
    );

    // wrdy is high only in IDLE/DONE, so the value held through BUSY is the accept-cycle data.
    always_ff @(posedge clk) begin
        if (wrdy) begin
            r_wdata <= w_line;
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_fire && !rst) begin
            r_mem[w_w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
        end else if (w_r_fire) begin
            r_line <= (w_w_fire && (w_w_idx == w_r_idx)) ? r_wdata : r_mem[w_r_idx];
        end
    end

endmodule

// File: tb/tb_ram_mc.sv
// Self-checking bench for ram_mc: vector table, scoreboard queue, corner sequences.
module tb_ram_mc;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] r_addr = '0;
    logic [31:0] w_addr = '0;
    logic [31:0] w_line = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] r_line;
    logic        rrdy, wrdy, r_exc, w_exc;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] sb[$];

    typedef struct {
        bit          wr;
        logic [31:0] idx;
        logic [31:0] data;
        bit          exc;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[11];

    ram_mc #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .RD_LAT(LAT), .WR_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .r_addr(r_addr), .w_addr(w_addr), .w_line(w_line),
        .read(read), .write(write), .r_line(r_line), .rrdy(rrdy), .wrdy(wrdy),
        .r_exc(r_exc), .w_exc(w_exc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] a(input logic [31:0] i);
`ifdef RAM_ALIGN_CHECK_EN
        return i << 2;
`else
        return i;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full handshake on one port; optionally hold the request after completion.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input bit exp_exc, input logic [31:0] exp_rd, input int hold,
                          input string nm);
        int busy;
        bit exc_busy;
        logic [31:0] e;
        if (!wr) sb.push_back(exp_rd);
        @(negedge clk);
        if (wr) begin w_addr = addr; w_line = data; write = 1'b1; end
        else    begin r_addr = addr; read = 1'b1; end
        busy = 0;
        exc_busy = 1'b0;
        @(negedge clk);
        while (!(wr ? wrdy : rrdy) && busy < 20) begin
            busy++;
            exc_busy |= (wr ? w_exc : r_exc);
            if (wr) begin w_addr = $urandom; w_line = $urandom; end else r_addr = $urandom;
            @(negedge clk);
        end
        chk({nm, " busy cycles"}, busy, exp_exc ? 1 : LAT);
        chk({nm, " exc while busy"}, {31'd0, exc_busy}, {31'd0, exp_exc});
        chk({nm, " exc at done"}, {31'd0, wr ? w_exc : r_exc}, {31'd0, exp_exc});
        if (!wr) begin
            e = sb.pop_front();
            chk({nm, " r_line"}, r_line, e);
        end
        for (int i = 0; i < hold; i++) begin
            if (wr) w_addr = $urandom; else r_addr = $urandom;
            @(negedge clk);
            chk({nm, " held rdy"}, {31'd0, wr ? wrdy : rrdy}, 32'd1);
        end
        if (hold > 0 && !wr) chk({nm, " held r_line"}, r_line, exp_rd);
        if (wr) write = 1'b0; else read = 1'b0;
        @(negedge clk);
        chk({nm, " rdy after drop"}, {31'd0, wr ? wrdy : rrdy}, 32'd1);
        chk({nm, " exc after drop"}, {31'd0, wr ? w_exc : r_exc}, 32'd0);
    endtask

    initial begin
        int cyc;
        tbl[0]  = '{1'b1, 32'd5,          32'hA5A5A5A5, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'd5,          32'h0,        1'b0, 32'hA5A5A5A5};
        tbl[2]  = '{1'b1, 32'd0,          32'h01234567, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'd1023,       32'hCAFEF00D, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'd0,          32'h0,        1'b0, 32'h01234567};
        tbl[5]  = '{1'b0, 32'd1023,       32'h0,        1'b0, 32'hCAFEF00D};
        tbl[6]  = '{1'b0, 32'd1024,       32'h0,        1'b1, 32'hCAFEF00D};
        tbl[7]  = '{1'b1, 32'd1024,       32'h55555555, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 32'h405,        32'h77777777, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 32'd5,          32'h0,        1'b0, 32'hA5A5A5A5};
        tbl[10] = '{1'b0, 32'h10000000,   32'h0,        1'b1, 32'hA5A5A5A5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset rrdy", {31'd0, rrdy}, 32'd1);
        chk("reset wrdy", {31'd0, wrdy}, 32'd1);
        chk("reset r_exc", {31'd0, r_exc}, 32'd0);
        chk("reset w_exc", {31'd0, w_exc}, 32'd0);
        chk("reset r_line", r_line, 32'd0);

        for (int i = 0; i < 11; i++)
            access(tbl[i].wr, a(tbl[i].idx), tbl[i].data, tbl[i].exc, tbl[i].exp, 0,
                   $sformatf("vec%0d", i));

        // Request held after completion must not start a second access.
        access(1'b0, a(5), 32'h0, 1'b0, 32'hA5A5A5A5, 5, "hold");
        access(1'b0, a(0), 32'h0, 1'b0, 32'h01234567, 0, "reassert");

        // Same-cycle write commit and read capture at one index: write-first.
        access(1'b1, a(9), 32'h11111111, 1'b0, 32'h0, 0, "preload9");
        sb.push_back(32'h12345678);
        @(negedge clk);
        w_addr = a(9); w_line = 32'h12345678; r_addr = a(9);
        write = 1'b1; read = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!(rrdy && wrdy) && cyc < 20) begin cyc++; @(negedge clk); end
        chk("collide busy", cyc, LAT);
        chk("collide r_line", r_line, sb.pop_front());
        write = 1'b0; read = 1'b0;
        @(negedge clk);

        // Reset on the commit edge of a write aborts it.
        access(1'b1, a(3), 32'h0BADF00D, 1'b0, 32'h0, 0, "preload3");
        @(negedge clk);
        w_addr = a(3); w_line = 32'hDEADBEEF; write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort wrdy busy", {31'd0, wrdy}, 32'd0);
        rst = 1'b1; write = 1'b0;
        @(negedge clk);
        chk("abort wrdy", {31'd0, wrdy}, 32'd1);
        chk("abort w_exc", {31'd0, w_exc}, 32'd0);
        chk("abort r_line", r_line, 32'd0);
        rst = 1'b0;
        access(1'b0, a(3), 32'h0, 1'b0, 32'h0BADF00D, 0, "after abort");

`ifdef RAM_ALIGN_CHECK_EN
        access(1'b0, 32'h6, 32'h0, 1'b1, 32'h0BADF00D, 0, "misaligned");
        access(1'b0, 32'h14, 32'h0, 1'b0, 32'hA5A5A5A5, 0, "aligned 0x14");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ram_mc.md
Name: ram_mc

Overview:
- Parametrised multi-cycle dual-port data RAM with independent read and write ports.
- Each port has a level request / ready handshake, a programmable access latency and a per-port out-of-range exception.
- Successor to the fixed 32-bit single-exception ram; sits between the processor load/store path and the memory bus, and is driven by the same memory testbench flow (request high, wait for ready low, check exception, wait for ready high).

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 32, address width in bits.
- DEPTH, 1024, number of words; valid word index is 0..DEPTH-1.
- RD_LAT, 2, read access latency in cycles (>=1).
- WR_LAT, 2, write access latency in cycles (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- r_addr  in  ADDR_W  read address.
- w_addr  in  ADDR_W  write address.
- w_line  in  DATA_W  write data.
- read  in  1  read request (level).
- write  in  1  write request (level).
- r_line  out  DATA_W  read data.
- rrdy  out  1  read port ready / done.
- wrdy  out  1  write port ready / done.
- r_exc  out  1  read exception.
- w_exc  out  1  write exception.

Behaviour:
- Reset: rrdy=wrdy=1, r_exc=w_exc=0, r_line=0, both ports go to IDLE. Array contents are not cleared. Reset mid-access aborts the access; an aborted write never commits.
- Per-port FSM: IDLE, BUSY, ERR, DONE. The read and write ports are identical and fully independent.
- IDLE (rdy=1, exc=0):
  - Request sampled high: latch address (and write data), then:
    - index >= DEPTH: go to ERR.
    - otherwise: load the latency counter with LAT-1 and go to BUSY.
- BUSY (rdy=0):
  - Counter decrements each cycle.
  - On the cycle it reaches 0:
    - Read port: r_line is loaded from array[latched index].
    - Write port: array[latched index] is written.
  - Then go to DONE.
  - Total: rdy is low for exactly LAT cycles.
- ERR (rdy=0, exc=1): lasts one cycle, no array access, r_line unchanged. Then go to DONE with exc still 1.
- DONE (rdy=1):
  - r_line and exc are held.
  - Stays while the request stays high; a new access is never started without the request first going low.
  - Request low: go to IDLE; exc clears on that transition.
- Address and data inputs are don't-care outside the accept cycle. Changes during BUSY are ignored.
- Collision: if a write commit and a read capture fall on the same cycle at the same index, r_line returns the new write data (write-first).
- Index is r_addr/w_addr truncated to $clog2(DEPTH) bits only after the range check. The range check uses the full ADDR_W value.

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined:
  - Addresses are byte addresses; index = addr >> $clog2(DATA_W/8).
  - Nonzero low $clog2(DATA_W/8) bits is a misaligned access and takes the ERR path like out-of-range.
  - Range check applies to the shifted index.
- Undefined: addresses are word indices and there is no alignment check.

Decomposition:
- Package ram_pkg:
  - Port state enum (IDLE/BUSY/ERR/DONE), 2-bit encoding.
  - Latency counter width function.
  - Localparam for the byte-offset width.
- Sub-module ram_port_ctl:
  - Contains the handshake FSM, latency counter, address latch, range/alignment check, and the outputs rdy, exc and fire (one-cycle strobe at completion).
  - Parametrised by LAT, instantiated once per port.
  - ram_mc owns the array and the r_line register.

Test Plan:
- Reset, then write 0xA5A5A5A5 to index 5 with WR_LAT=2 → wrdy low exactly 2 cycles, w_exc=0. Then read index 5 → r_line=0xA5A5A5A5 when rrdy rises after 2 cycles.
- Read index DEPTH (1024) → rrdy low 1 cycle with r_exc=1, rrdy back high with r_exc held 1, r_line unchanged. Dropping read clears r_exc next cycle.
- Hold read high after completion for 5 cycles → no second access, rrdy stays 1. Drop and reassert → new access with a fresh 2-cycle busy.
- Simultaneous write 0x12345678 and read at index 9 with RD_LAT=WR_LAT → r_line=0x12345678 (write-first).
- Assert rst during BUSY of a write of 0xDEADBEEF to index 3 → next cycle wrdy=1, w_exc=0; later read of index 3 returns the prior contents.
- With RAM_ALIGN_CHECK_EN: read addr 0x6 → r_exc=1. Read addr 0x14 → returns word index 5.
